// File: rtl/noc_packetizer.sv
// noc_packetizer: message request + body stream to flit stream.
// Feeds the router LOCAL input port, one registered flit per cycle.
package noc_pkg;
  localparam int DEST_ADDR_SIZE_X = 6;
  localparam int DEST_ADDR_SIZE_Y = 3;
  localparam int FLIT_DATA_SIZE = 82;
  localparam int HEAD_PAYLOAD_SIZE = 73;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    TAIL     = 2'b01,
    HEAD     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t flit_label;
    flit_data_t  data;
  } flit_novc_t;
endpackage

module noc_packetizer
  import noc_pkg::*;
#(
  parameter logic [DEST_ADDR_SIZE_X-1:0] SRC_X = '0,
  parameter logic [DEST_ADDR_SIZE_Y-1:0] SRC_Y = '0,
  parameter int MAX_BODY_FLITS = 15,
  localparam int LEN_W = $clog2(MAX_BODY_FLITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_x_dest,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_y_dest,
  input  logic [63:0]                 req_data,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        body_valid,
  output logic                        body_ready,
  input  logic [FLIT_DATA_SIZE-1:0]   body_data,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output flit_novc_t                  flit_out,
  output logic                        busy
);

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             vld_q, vld_d;
  flit_novc_t       flit_q, flit_d;
  logic             out_free;

  assign out_free   = !vld_q || flit_ready;
  assign flit_valid = vld_q;
  assign flit_out   = flit_q;
  assign busy       = (state_q != ST_IDLE);

  // State, counter and output flit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      flit_q  <= flit_d;
    end
  end

  // Next state, handshakes and next flit; the output slot may
  // be refilled in the same cycle its current flit drains
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    vld_d      = out_free ? 1'b0 : vld_q;
    flit_d     = flit_q;
    req_ready  = 1'b0;
    body_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = out_free && !rst;
        if (req_valid && out_free) begin
          vld_d = 1'b1;
          flit_d.flit_label = (req_len == '0) ? HEADTAIL : HEAD;
          flit_d.data.head.x_dest = req_x_dest;
          flit_d.data.head.y_dest = req_y_dest;
          flit_d.data.head.head_pl = {SRC_X, SRC_Y, req_data};
          rem_d = req_len;
          state_d = (req_len == '0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        body_ready = out_free;
        if (body_valid && out_free) begin
          vld_d = 1'b1;
          flit_d.flit_label =
            (rem_q == LEN_W'(1)) ? TAIL : BODY;
          flit_d.data.bt_pl = body_data;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Oversized packet length is illegal
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready)
      assert (int'(req_len) <= MAX_BODY_FLITS);
  end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Injection-side network interface stage that converts a message request plus an optional body-word stream into a flit stream of type flit_novc_t.
- Its output is the router LOCAL input port.
- Builds HEAD/BODY/TAIL/HEADTAIL labels and inserts the source coordinates into the head payload.
- Registered valid/ready output sustains one flit per cycle.

Parameters:
- SRC_X, 0, this node's X coordinate; width DEST_ADDR_SIZE_X (6).
- SRC_Y, 0, this node's Y coordinate; width DEST_ADDR_SIZE_Y (3).
- MAX_BODY_FLITS, 15, maximum body+tail flits per packet; LEN_W = $clog2(MAX_BODY_FLITS+1).
- Widths come from noc_pkg: FLIT_DATA_SIZE = 82, HEAD_PAYLOAD_SIZE = 73, flit_novc_t = 84 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  packet request valid
- req_ready  out  1  packet request accepted
- req_x_dest  in  DEST_ADDR_SIZE_X  destination X
- req_y_dest  in  DEST_ADDR_SIZE_Y  destination Y
- req_data  in  64  head user payload
- req_len  in  LEN_W  number of flits after the head; 0 means single HEADTAIL flit
- body_valid  in  1  body word valid
- body_ready  out  1  body word accepted
- body_data  in  FLIT_DATA_SIZE  body/tail payload (bt_pl)
- flit_valid  out  1  output flit valid
- flit_ready  in  1  downstream accepts flit
- flit_out  out  84  flit_novc_t
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, remaining=0, flit_valid=0, flit_out=0, req_ready=0 while rst is high, busy=0.
- out_free = !flit_valid || flit_ready. The output register may be loaded in the same cycle it is being drained.
- FSM states: IDLE, BODY.
- IDLE:
  - req_ready = out_free; body_ready = 0.
  - On req fire, next cycle: flit_valid=1, flit_label = (req_len==0) ? HEADTAIL : HEAD.
  - On req fire, next cycle: head_data = {x_dest=req_x_dest, y_dest=req_y_dest, head_pl={SRC_X, SRC_Y, req_data}}.
  - remaining <= req_len; state <= (req_len==0) ? IDLE : BODY.
- BODY:
  - req_ready = 0; body_ready = out_free.
  - On body fire: flit_valid=1, bt_pl = body_data, label = (remaining==1) ? TAIL : BODY.
  - On body fire: remaining decrements; at remaining==1, state <= IDLE.
- No fire while out_free=1: flit_valid <= 0 on the clock edge after the current flit is taken.
- Latency: 1 cycle from any input fire to flit_valid.
- Throughput: back-to-back packets with no bubble. The HEAD of packet N+1 may load in the cycle after the TAIL of packet N is loaded.
- Hold rule: while flit_valid && !flit_ready, flit_out and flit_valid stay stable and both input readies are 0.
- Ignored inputs: body_valid in IDLE and req_valid in BODY are ignored; no data is consumed.
- Unused flit bits: flit_out data bits not written by the current label keep the union overlay of the loaded field; whole 82-bit data is written every load.
- req_len > MAX_BODY_FLITS is illegal; a simulation assertion fires and no behaviour is guaranteed.
- Reset mid-packet: state returns to IDLE and the pending flit is dropped. No TAIL is emitted; upstream must also reset.
- busy is registered from the state, not from flit_valid.

Test Plan:
- Single-flit packet: req_len=0, x=5, y=2, data=64'hDEAD_BEEF_0123_4567, SRC=(3,1), flit_ready=1 -> one flit next cycle. Label HEADTAIL, x_dest=5, y_dest=2, head_pl={6'd3,3'd1,data}; busy stays 0.
- Three-flit packet: req_len=2, body words A then B, all ready -> HEAD, BODY(A), TAIL(B) on 3 consecutive cycles; busy high for 2 cycles.
- Backpressure: flit_ready=0 for 4 cycles during the BODY flit -> flit_out is constant, body_ready=0, and no body word is lost. Resumes with TAIL one cycle after ready returns.
- Back-to-back packets: req_len=1 then req_len=0 held valid -> HEAD, TAIL, HEADTAIL on 3 consecutive cycles with no bubble.
- Ignored inputs: body_valid=1 in IDLE -> body_ready=0 and no flit. req_valid=1 in BODY -> req_ready=0.
- Async reset mid-packet after HEAD of a req_len=3 packet -> flit_valid=0 and busy=0 immediately. Next request produces a fresh HEAD.
